// File: rtl/wb_line_sram.sv
`default_nettype none
// ============================================================================
// wb_line_sram : Wishbone classic slave serving full cache-line reads and
//                byte-masked writes from a narrower synchronous SRAM.
// Revision     : 1.0
// ============================================================================
module wb_line_sram #(
  parameter int LINE_WIDTH       = 128,
  parameter int ADDR_WIDTH       = 32,
  parameter int ADDR_GRANULARITY = 8,
  parameter int MEM_WIDTH        = 32,
  parameter int MEM_LINES        = 4096,
  localparam int BEATS           = LINE_WIDTH / MEM_WIDTH,
  localparam int MEM_ADDR_WIDTH  = $clog2(MEM_LINES * BEATS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ADDR_WIDTH-1:0]                    wb_adr_i,
  input  logic [LINE_WIDTH-1:0]                    wb_dat_i,
  output logic [LINE_WIDTH-1:0]                    wb_dat_o,
  input  logic                                     wb_we_i,
  input  logic [LINE_WIDTH/ADDR_GRANULARITY-1:0]   wb_sel_i,
  input  logic                                     wb_stb_i,
  input  logic                                     wb_cyc_i,
  output logic                                     wb_ack_o,
  output logic                                     wb_err_o,
  output logic                                     wb_rty_o,
  output logic                                     mem_en,
  output logic                                     mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]                mem_addr,
  output logic [MEM_WIDTH/ADDR_GRANULARITY-1:0]    mem_be,
  output logic [MEM_WIDTH-1:0]                     mem_wdata,
  input  logic [MEM_WIDTH-1:0]                     mem_rdata
);

  localparam int SEL_WIDTH = LINE_WIDTH / ADDR_GRANULARITY;
  localparam int BE_WIDTH  = MEM_WIDTH / ADDR_GRANULARITY;
  localparam int BEAT_W    = $clog2(BEATS);
  localparam int LINE_OFF  = $clog2(SEL_WIDTH);
  localparam int IDX_W     = ADDR_WIDTH - LINE_OFF;
  localparam int LINE_W    = MEM_ADDR_WIDTH - BEAT_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_LAST = 3'd2,
    S_WR      = 3'd3,
    S_ACK     = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [LINE_W-1:0]     r_line;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [LINE_WIDTH-1:0] r_dat;
  logic [LINE_WIDTH-1:0] r_buf;
  logic [BEATS-1:0]      r_mask;
  logic [BEAT_W-1:0]     r_beat;

  logic                  w_req;
  logic                  w_oob;
  logic                  w_capture;
  logic [IDX_W-1:0]      w_idx;
  logic [BEATS-1:0]      w_req_mask;
  logic [BEATS-1:0]      w_mask_clr;
  logic [BEAT_W-1:0]     w_wr_beat;
  logic [BEAT_W-1:0]     w_cap_idx;
  logic [BE_WIDTH-1:0]   w_sel_beat [BEATS];
  logic [MEM_WIDTH-1:0]  w_dat_beat [BEATS];
  logic                  w_unused;

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_idx     = wb_adr_i[ADDR_WIDTH-1:LINE_OFF];
  assign w_oob     = (w_idx >= IDX_W'(MEM_LINES));
  assign w_unused  = &{1'b0, wb_adr_i[LINE_OFF-1:0]};
  assign w_cap_idx = r_beat - BEAT_W'(1);

  // Capture lags issue by one cycle; in RD_LAST the beat counter has wrapped to 0,
  // so r_beat-1 names the final slice.
  assign w_capture = wb_cyc_i &&
                     (((r_state == S_RD) && (r_beat != '0)) || (r_state == S_RD_LAST));

  generate
    for (genvar k = 0; k < BEATS; k++) begin : g_beat
      assign w_req_mask[k] = |wb_sel_i[k*BE_WIDTH +: BE_WIDTH];
      assign w_sel_beat[k] = r_sel[k*BE_WIDTH +: BE_WIDTH];
      assign w_dat_beat[k] = r_dat[k*MEM_WIDTH +: MEM_WIDTH];
    end
  endgenerate

  always_comb begin
    w_wr_beat = '0;
    for (int i = BEATS - 1; i >= 0; i--) begin
      if (r_mask[i]) w_wr_beat = BEAT_W'(i);
    end
  end

  assign w_mask_clr = r_mask & ~(BEATS'(1) << w_wr_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_oob)                     w_next = S_ERR;
          else if (!wb_we_i)             w_next = S_RD;
          else if (w_req_mask == '0)     w_next = S_ACK;
          else                           w_next = S_WR;
        end
      end
      S_RD: begin
        if (!wb_cyc_i)                           w_next = S_IDLE;
        else if (r_beat == BEAT_W'(BEATS - 1))   w_next = S_RD_LAST;
      end
      S_RD_LAST: w_next = wb_cyc_i ? S_ACK : S_IDLE;
      S_WR: begin
        if (!wb_cyc_i)               w_next = S_IDLE;
        else if (w_mask_clr == '0)   w_next = S_ACK;
      end
      S_ACK:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
      r_sel  <= '0;
      r_dat  <= '0;
      r_mask <= '0;
      r_beat <= '0;
      r_buf  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_line <= w_idx[LINE_W-1:0];
            r_sel  <= wb_sel_i;
            r_dat  <= wb_dat_i;
            r_mask <= wb_we_i ? w_req_mask : '0;
            r_beat <= '0;
          end
        end
        S_RD:    if (wb_cyc_i) r_beat <= r_beat + BEAT_W'(1);
        S_WR:    if (wb_cyc_i) r_mask <= w_mask_clr;
        default: ;
      endcase
      if (w_capture) begin
        for (int i = 0; i < BEATS; i++) begin
          if (w_cap_idx == BEAT_W'(i)) r_buf[i*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata;
        end
      end
    end
  end

  // SRAM strobes are gated by cyc so an abort stops issue in the same cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (wb_cyc_i) begin
      case (r_state)
        S_RD: begin
          mem_en   = 1'b1;
          mem_addr = {r_line, r_beat};
        end
        S_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {r_line, w_wr_beat};
          mem_be    = w_sel_beat[w_wr_beat];
          mem_wdata = w_dat_beat[w_wr_beat];
        end
        default: ;
      endcase
    end
  end

  assign wb_ack_o = (r_state == S_ACK);
  assign wb_err_o = (r_state == S_ERR);
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_wb_line_sram.sv
`default_nettype none
// ============================================================================
// tb_wb_line_sram : directed self-checking bench for wb_line_sram with an SRAM model.
// Revision        : 1.0
// ============================================================================
module tb_wb_line_sram;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  wb_adr_i;
  logic [127:0] wb_dat_i;
  logic [127:0] wb_dat_o;
  logic         wb_we_i;
  logic [15:0]  wb_sel_i;
  logic         wb_stb_i;
  logic         wb_cyc_i;
  logic         wb_ack_o;
  logic         wb_err_o;
  logic         wb_rty_o;
  logic         mem_en;
  logic         mem_we;
  logic [13:0]  mem_addr;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  wb_line_sram dut (
    .clk       (clk),
    .rst       (rst),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_rty_o  (wb_rty_o),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-enabled writes, read data one cycle after issue, plus a preload port.
  logic [31:0] sram [0:16383];
  logic        ld_en;
  logic [13:0] ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) begin
      sram[ld_addr] <= ld_data;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [13:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  logic [13:0]  iss_addr [$];
  logic [3:0]   iss_be   [$];
  logic [31:0]  iss_wd   [$];
  int           n_wr, ack_at, ack_cnt, err_at, err_cnt;
  logic [127:0] ack_dat;

  // One transaction observed over a fixed 12-cycle window; cycle c = c-th negedge after request edge.
  task automatic txn(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                     input logic [127:0] dat, input int abort_after);
    iss_addr.delete(); iss_be.delete(); iss_wd.delete();
    n_wr = 0; ack_at = 0; ack_cnt = 0; err_at = 0; err_cnt = 0; ack_dat = '0;
    wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_en) begin
        iss_addr.push_back(mem_addr);
        iss_be.push_back(mem_be);
        iss_wd.push_back(mem_wdata);
        if (mem_we) n_wr++;
      end
      if (wb_ack_o) begin ack_cnt++; if (ack_at == 0) ack_at = c; ack_dat = wb_dat_o; end
      if (wb_err_o) begin err_cnt++; if (err_at == 0) err_at = c; end
      if (wb_ack_o || wb_err_o || (abort_after >= 0 && iss_addr.size() == abort_after)) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ack",   128'(wb_ack_o),  128'd0);
    chk("rst_err",   128'(wb_err_o),  128'd0);
    chk("rst_rty",   128'(wb_rty_o),  128'd0);
    chk("rst_en",    128'({mem_en, mem_we}), 128'd0);
    chk("rst_addr",  128'(mem_addr),  128'd0);
    chk("rst_be_wd", 128'({mem_be, mem_wdata}), 128'd0);
    chk("rst_dat",   wb_dat_o,        128'd0);

    ld(14'h40, 32'h11111111); ld(14'h41, 32'h22222222);
    ld(14'h42, 32'h33333333); ld(14'h43, 32'h44444444);
    ld(14'h80, 32'hA0A0A0A0); ld(14'h81, 32'hB1B1B1B1);
    ld(14'h82, 32'hC2C2C2C2); ld(14'h83, 32'hD3D3D3D3);
    rst = 1'b0;
    @(negedge clk);

    // Full line read
    txn(32'h100, 1'b0, 16'h0000, '0, -1);
    chk("rd_issues", 128'(iss_addr.size()), 128'd4);
    chk("rd_addr0",  128'(iss_addr[0]), 128'h40);
    chk("rd_addr1",  128'(iss_addr[1]), 128'h41);
    chk("rd_addr2",  128'(iss_addr[2]), 128'h42);
    chk("rd_addr3",  128'(iss_addr[3]), 128'h43);
    chk("rd_nowr",   128'(n_wr), 128'd0);
    chk("rd_ack_at", 128'(ack_at), 128'd6);
    chk("rd_ack_n",  128'(ack_cnt), 128'd1);
    chk("rd_data",   ack_dat, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    chk("rd_hold",   wb_dat_o, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

    // Single-word writethrough
    txn(32'h104, 1'b1, 16'h00F0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, -1);
    chk("w1_issues", 128'(iss_addr.size()), 128'd1);
    chk("w1_addr",   128'(iss_addr[0]), 128'h41);
    chk("w1_be",     128'(iss_be[0]), 128'hF);
    chk("w1_wdata",  128'(iss_wd[0]), 128'hDEADBEEF);
    chk("w1_we",     128'(n_wr), 128'd1);
    chk("w1_ack_at", 128'(ack_at), 128'd2);

    txn(32'h100, 1'b0, 16'h0000, '0, -1);
    chk("rr1_data",  ack_dat, {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111});

    // Sparse write, beats 0 and 2
    txn(32'h100, 1'b1, 16'h0F0F, {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888}, -1);
    chk("w2_issues", 128'(iss_addr.size()), 128'd2);
    chk("w2_addr0",  128'(iss_addr[0]), 128'h40);
    chk("w2_addr1",  128'(iss_addr[1]), 128'h42);
    chk("w2_wd0",    128'(iss_wd[0]), 128'h88888888);
    chk("w2_wd1",    128'(iss_wd[1]), 128'h66666666);
    chk("w2_ack_at", 128'(ack_at), 128'd3);

    // Empty select write
    txn(32'h100, 1'b1, 16'h0000, {4{32'hFFFFFFFF}}, -1);
    chk("w0_issues", 128'(iss_addr.size()), 128'd0);
    chk("w0_ack_at", 128'(ack_at), 128'd1);
    chk("w0_ack_n",  128'(ack_cnt), 128'd1);

    // Out-of-range line
    txn(32'h10000, 1'b0, 16'h0000, '0, -1);
    chk("err_at",     128'(err_at), 128'd1);
    chk("err_n",      128'(err_cnt), 128'd1);
    chk("err_issues", 128'(iss_addr.size()), 128'd0);
    chk("err_noack",  128'(ack_cnt), 128'd0);

    // Abort after second read beat, then a normal read (low address bits ignored)
    txn(32'h100, 1'b0, 16'h0000, '0, 2);
    chk("ab_issues", 128'(iss_addr.size()), 128'd2);
    chk("ab_addr1",  128'(iss_addr[1]), 128'h41);
    chk("ab_noack",  128'(ack_cnt), 128'd0);
    txn(32'h10C, 1'b0, 16'h0000, '0, -1);
    chk("ab_rd_ack", 128'(ack_at), 128'd6);
    chk("ab_rd_dat", ack_dat, {32'h44444444, 32'h66666666, 32'hDEADBEEF, 32'h88888888});

    // Partial-byte write
    txn(32'h200, 1'b1, 16'h0030, {32'h0, 32'h0, 32'h12345678, 32'h0}, -1);
    chk("pb_addr",   128'(iss_addr[0]), 128'h81);
    chk("pb_be",     128'(iss_be[0]), 128'h3);
    chk("pb_ack_at", 128'(ack_at), 128'd2);

    // Reset in the middle of a full-line write
    wb_adr_i = 32'h200; wb_we_i = 1'b1; wb_sel_i = 16'hFFFF;
    wb_dat_i = {32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB};
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk);
    chk("rw_addr0", 128'({mem_en, mem_we, mem_addr}), {112'd0, 2'b11, 14'h80});
    @(negedge clk);
    chk("rw_addr1", 128'({mem_en, mem_we, mem_addr}), {112'd0, 2'b11, 14'h81});
    rst = 1'b1;
    #1;
    chk("rw_rst_en",  128'({mem_en, mem_we}), 128'd0);
    chk("rw_rst_out", 128'({mem_addr, mem_be, mem_wdata}), 128'd0);
    chk("rw_rst_wb",  128'({wb_ack_o, wb_err_o, wb_rty_o}), 128'd0);
    chk("rw_rst_dat", wb_dat_o, 128'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_ack_o) ack_cnt++;
    end
    chk("rw_noack", 128'(ack_cnt), 128'd0);
    txn(32'h200, 1'b0, 16'h0000, '0, -1);
    chk("rw_rd_dat", ack_dat, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B15678, 32'hBBBBBBBB});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_line_sram.md
# wb_line_sram

Wishbone classic slave (responder) serving full cache-line transfers from a narrower synchronous SRAM. Sits on the far side of the cache controller's arbitrated bus: accepts 128-bit line reads and byte-masked line writes, serializes them into MEM_WIDTH-wide SRAM beats, and returns one ack per transaction. Sparse writes skip beats with an all-zero select slice, so single-word writethroughs cost one SRAM cycle.

## Interface
- LINE_WIDTH, 128: Wishbone data width (one cache line)
- ADDR_WIDTH, 32: Wishbone byte address width
- ADDR_GRANULARITY, 8: bits per select lane
- MEM_WIDTH, 32: SRAM data width; LINE_WIDTH/MEM_WIDTH = BEATS (power of two)
- MEM_LINES, 4096: mapped lines; MEM_ADDR_WIDTH = clog2(MEM_LINES*BEATS)

- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- wb_adr_i  in  ADDR_WIDTH  byte address; low clog2(LINE_WIDTH/ADDR_GRANULARITY) bits ignored
- wb_dat_i  in  LINE_WIDTH  write line
- wb_dat_o  out  LINE_WIDTH  read line, valid while wb_ack_o
- wb_we_i  in  1  write enable
- wb_sel_i  in  LINE_WIDTH/ADDR_GRANULARITY  byte lane selects
- wb_stb_i, wb_cyc_i  in  1  strobe / cycle
- wb_ack_o, wb_err_o, wb_rty_o  out  1  ack / error / retry (rty tied 0)
- mem_en  out  1  SRAM access this cycle
- mem_we  out  1  SRAM write
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address = {line index, beat}
- mem_be  out  MEM_WIDTH/ADDR_GRANULARITY  SRAM byte enables
- mem_wdata  out  MEM_WIDTH  SRAM write data
- mem_rdata  in  MEM_WIDTH  SRAM read data, valid the cycle after a read issue

## Operation
- States: IDLE, RD, RD_LAST, WR, ACK, ERR.
- IDLE: on wb_cyc_i & wb_stb_i, latch line index, we, sel, dat_i. Line index >= MEM_LINES -> ERR. Read -> RD, beat=0. Write: mask[k] = |sel slice k; mask==0 -> ACK, else WR.
- RD: mem_en=1, mem_we=0, mem_addr={line, beat}; beat increments; after beat BEATS-1 -> RD_LAST. Each cycle captures mem_rdata of previous issue into buffer slice beat-1.
- RD_LAST: capture final slice -> ACK.
- WR: issue lowest set mask bit k: mem_en=mem_we=1, mem_be=sel slice k, mem_wdata=dat slice k; clear bit; mask becomes 0 -> ACK.
- ACK: wb_ack_o=1 one cycle, wb_dat_o=buffer (reads) -> IDLE. ERR: wb_err_o=1 one cycle, no SRAM access -> IDLE.
- Abort: wb_cyc_i low in RD/RD_LAST/WR -> IDLE next edge, no ack, no further beats; already-issued writes stand; pending read data discarded.
- Ack/err are registered state outputs, never combinational from inputs. Master holding stb high in the cycle after ack starts a new transaction.
- wb_dat_o changes only on buffer capture; holds last line otherwise.

## Timing
- Reset (async): state IDLE; wb_ack_o=wb_err_o=wb_rty_o=0; mem_en=mem_we=0; mem_addr, mem_be, mem_wdata, wb_dat_o = 0; mask/beat = 0. Reset mid-transaction drops mem_en immediately, no ack afterward.
- Request sampled at edge T. Read: issues T+1..T+BEATS, RD_LAST T+BEATS+1, ack in cycle T+BEATS+2 (T+6 at defaults).
- Write with n active beats: issues T+1..T+n, ack in cycle T+n+1; n=0 acks in T+1.
- Error: wb_err_o in cycle T+1.
- Back-to-back: next request earliest sampled in the cycle after ack.

## Test plan
- Preload SRAM words 0x40..0x43 = 11111111,22222222,33333333,44444444; read wb_adr_i=0x100 -> mem_addr 0x40..0x43 on 4 cycles, ack at T+6, wb_dat_o=0x44444444_33333333_22222222_11111111.
- Write wb_adr_i=0x104, sel=0x00F0, dat word1=0xDEADBEEF -> single beat mem_addr 0x41, mem_be=0xF, ack at T+2; reread line shows only word1 changed.
- Write sel=0x0F0F -> beats 0 and 2 only, ack at T+3; sel=0x0000 -> no mem_en, ack at T+1.
- Read line index MEM_LINES (adr 0x10000 at defaults) -> wb_err_o one cycle at T+1, mem_en never asserted, no ack.
- Drop wb_cyc_i after second read beat -> no further mem_en, no ack, IDLE next cycle; following read completes normally.
- Assert rst mid-write -> mem_en/mem_we low same cycle, all outputs zero; after release, read returns only the beats written before reset.
